// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with a registered EX/MEM output bundle.
// Define EX_MULDIV_EN to build the iterative 32-step MUL/DIVU/REMU unit.
module ex_stage #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VALUE = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            flush_in,
   input  logic [XLEN-1:0] src_data_a_in,
   input  logic [XLEN-1:0] src_data_b_in,
   input  logic [XLEN-1:0] imm_value_in,
   input  logic [4:0]      dest_reg_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [3:0]      ex_control_in,
   input  logic            reg_write_en_in,
   input  logic            mem_write_en_in,
   input  logic            memory_enable_in,
   output logic            stall_out,
   output logic [XLEN-1:0] result_out,
   output logic [XLEN-1:0] store_data_out,
   output logic [4:0]      dest_reg_out,
   output logic [XLEN-1:0] pc_out,
   output logic            reg_write_en_out,
   output logic            mem_write_en_out,
   output logic            memory_enable_out,
   output logic            out_valid
);

   function automatic logic [XLEN-1:0] alu_op(
      input logic [3:0]      op,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b,
      input logic [XLEN-1:0] imm,
      input logic [XLEN-1:0] pc
   );
      logic [4:0]      sh;
      logic [XLEN-1:0] r;
      sh = b[4:0];
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << sh;
         4'd6:    r = a >> sh;
         4'd7:    r = XLEN'($signed(a) >>> sh);
         4'd8:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd9:    r = {{(XLEN-1){1'b0}}, (a < b)};
         4'd13:   r = imm;
         4'd14:   r = pc + imm;
         4'd15:   r = a + imm;
         default: r = {XLEN{1'b0}};
      endcase
      return r;
   endfunction

   logic [XLEN-1:0] alu_res;
   logic            ld;
   logic [XLEN-1:0] ld_res;
   logic [XLEN-1:0] ld_store;
   logic [4:0]      ld_dest;
   logic [XLEN-1:0] ld_pc;
   logic            ld_rwe;
   logic            ld_mwe;
   logic            ld_me;

   // Single-cycle result; a memory access always computes base + offset.
   always_comb begin
      if (memory_enable_in) begin
         alu_res = src_data_a_in + imm_value_in;
      end else begin
         alu_res = alu_op(ex_control_in, src_data_a_in, src_data_b_in, imm_value_in, pc_in);
      end
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   localparam int            CW       = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] q;
   logic [XLEN-1:0] d;
   logic [3:0]      md_op;
   logic [XLEN-1:0] md_store;
   logic [4:0]      md_dest;
   logic [XLEN-1:0] md_pc;
   logic            md_rwe;
   logic            md_mwe;
   logic            is_md;
   logic [XLEN:0]   rem_sh;
   logic            rem_lt;
   logic [XLEN-1:0] rem_diff;
   logic [XLEN-1:0] md_result;

   assign is_md = !memory_enable_in &&
                  (ex_control_in == 4'd10 || ex_control_in == 4'd11 || ex_control_in == 4'd12);

   // Restoring-divide step: shift the next dividend bit into the partial remainder.
   always_comb begin
      rem_sh   = {acc, q[XLEN-1]};
      rem_lt   = (rem_sh < {1'b0, d});
      rem_diff = rem_sh[XLEN-1:0] - d;
   end

   // Final result selection once all iterations are complete.
   always_comb begin
      case (md_op)
         4'd10:   md_result = acc;
         4'd11:   md_result = q;
         4'd12:   md_result = acc;
         default: md_result = {XLEN{1'b0}};
      endcase
   end

   // Stall is combinational so the hold takes effect in the issuing cycle.
   always_comb begin
      if (rst || flush_in) begin
         stall_out = 1'b0;
      end else begin
         case (state)
            IDLE:    stall_out = in_valid && is_md;
            BUSY:    stall_out = 1'b1;
            DONE:    stall_out = 1'b0;
            default: stall_out = 1'b0;
         endcase
      end
   end

   // Multiply/divide sequencer: latch, 32 iterations, then hand off to the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= {CW{1'b0}};
         acc      <= {XLEN{1'b0}};
         q        <= {XLEN{1'b0}};
         d        <= {XLEN{1'b0}};
         md_op    <= 4'd0;
         md_store <= {XLEN{1'b0}};
         md_dest  <= 5'd0;
         md_pc    <= {XLEN{1'b0}};
         md_rwe   <= 1'b0;
         md_mwe   <= 1'b0;
      end else if (flush_in) begin
         state <= IDLE;
         cnt   <= {CW{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && is_md) begin
                  state    <= BUSY;
                  cnt      <= {CW{1'b0}};
                  acc      <= {XLEN{1'b0}};
                  md_op    <= ex_control_in;
                  md_store <= src_data_b_in;
                  md_dest  <= dest_reg_in;
                  md_pc    <= pc_in;
                  md_rwe   <= reg_write_en_in;
                  md_mwe   <= mem_write_en_in;
                  if (ex_control_in == 4'd10) begin
                     q <= src_data_b_in;
                     d <= src_data_a_in;
                  end else begin
                     q <= src_data_a_in;
                     d <= src_data_b_in;
                  end
               end
            end
            BUSY: begin
               if (md_op == 4'd10) begin
                  acc <= q[0] ? (acc + d) : acc;
                  d   <= d << 1;
                  q   <= q >> 1;
               end else if (!rem_lt) begin
                  acc <= rem_diff;
                  q   <= {q[XLEN-2:0], 1'b1};
               end else begin
                  acc <= rem_sh[XLEN-1:0];
                  q   <= {q[XLEN-2:0], 1'b0};
               end
               cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
               if (cnt == CNT_LAST) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Output-register source: fresh instruction in IDLE, held metadata in DONE.
   always_comb begin
      ld       = 1'b0;
      ld_res   = alu_res;
      ld_store = src_data_b_in;
      ld_dest  = dest_reg_in;
      ld_pc    = pc_in;
      ld_rwe   = reg_write_en_in;
      ld_mwe   = mem_write_en_in;
      ld_me    = memory_enable_in;
      case (state)
         IDLE: ld = in_valid && !is_md;
         BUSY: ld = 1'b0;
         DONE: begin
            ld       = 1'b1;
            ld_res   = md_result;
            ld_store = md_store;
            ld_dest  = md_dest;
            ld_pc    = md_pc;
            ld_rwe   = md_rwe;
            ld_mwe   = md_mwe;
            ld_me    = 1'b0;
         end
         default: ld = 1'b0;
      endcase
   end
`else
   assign stall_out = 1'b0;

   // Without the multiplier every op, including 10..12, completes in one cycle.
   always_comb begin
      ld       = in_valid;
      ld_res   = alu_res;
      ld_store = src_data_b_in;
      ld_dest  = dest_reg_in;
      ld_pc    = pc_in;
      ld_rwe   = reg_write_en_in;
      ld_mwe   = mem_write_en_in;
      ld_me    = memory_enable_in;
   end
`endif

   // EX/MEM register; a bubble or flush clears valid and enables but holds data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_out        <= RESET_VALUE;
         store_data_out    <= RESET_VALUE;
         pc_out            <= RESET_VALUE;
         dest_reg_out      <= 5'd0;
         reg_write_en_out  <= 1'b0;
         mem_write_en_out  <= 1'b0;
         memory_enable_out <= 1'b0;
         out_valid         <= 1'b0;
      end else if (flush_in || !ld) begin
         reg_write_en_out  <= 1'b0;
         mem_write_en_out  <= 1'b0;
         memory_enable_out <= 1'b0;
         out_valid         <= 1'b0;
      end else begin
         result_out        <= ld_res;
         store_data_out    <= ld_store;
         pc_out            <= ld_pc;
         dest_reg_out      <= ld_dest;
         reg_write_en_out  <= ld_rwe;
         mem_write_en_out  <= ld_mwe;
         memory_enable_out <= ld_me;
         out_valid         <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiply/divide steps are built
// only when EX_MULDIV_EN is defined, otherwise ops 10..12 are checked as zero.
module tb_ex_stage;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        flush_in;
   logic [31:0] src_data_a_in;
   logic [31:0] src_data_b_in;
   logic [31:0] imm_value_in;
   logic [4:0]  dest_reg_in;
   logic [31:0] pc_in;
   logic [3:0]  ex_control_in;
   logic        reg_write_en_in;
   logic        mem_write_en_in;
   logic        memory_enable_in;
   logic        stall_out;
   logic [31:0] result_out;
   logic [31:0] store_data_out;
   logic [4:0]  dest_reg_out;
   logic [31:0] pc_out;
   logic        reg_write_en_out;
   logic        mem_write_en_out;
   logic        memory_enable_out;
   logic        out_valid;

   int tests = 0;
   int fails = 0;

   ex_stage #(.XLEN(32), .RESET_VALUE(32'h0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush_in(flush_in),
      .src_data_a_in(src_data_a_in), .src_data_b_in(src_data_b_in),
      .imm_value_in(imm_value_in), .dest_reg_in(dest_reg_in), .pc_in(pc_in),
      .ex_control_in(ex_control_in), .reg_write_en_in(reg_write_en_in),
      .mem_write_en_in(mem_write_en_in), .memory_enable_in(memory_enable_in),
      .stall_out(stall_out), .result_out(result_out), .store_data_out(store_data_out),
      .dest_reg_out(dest_reg_out), .pc_out(pc_out), .reg_write_en_out(reg_write_en_out),
      .mem_write_en_out(mem_write_en_out), .memory_enable_out(memory_enable_out),
      .out_valid(out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic me, input logic mwe, input logic rwe);
      in_valid         = 1'b1;
      ex_control_in    = op;
      src_data_a_in    = a;
      src_data_b_in    = b;
      imm_value_in     = imm;
      memory_enable_in = me;
      mem_write_en_in  = mwe;
      reg_write_en_in  = rwe;
   endtask

`ifdef EX_MULDIV_EN
   // Run one iterative op to completion and check stall length and result.
   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n;
      logic ov_seen;
      n = 0;
      ov_seen = 1'b0;
      drive(op, a, b, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      while (stall_out === 1'b1 && n < 40) begin
         n++;
         tick();
         if (out_valid !== 1'b0) ov_seen = 1'b1;
      end
      chk({tag, "_stall_cycles"}, n, 32'd33);
      chk({tag, "_busy_valid"}, {31'd0, ov_seen}, 32'd0);
      tick();
      chk({tag, "_result"}, result_out, exp);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush_in = 1'b0;
      src_data_a_in = 32'h0; src_data_b_in = 32'h0; imm_value_in = 32'h0;
      dest_reg_in = 5'd0; pc_in = 32'h0; ex_control_in = 4'd0;
      reg_write_en_in = 1'b0; mem_write_en_in = 1'b0; memory_enable_in = 1'b0;
      #12;
      chk("rst_result", result_out, 32'h0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ADD with signed overflow wraps
      dest_reg_in = 5'd5; pc_in = 32'h100;
      drive(4'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("add_stall", {31'd0, stall_out}, 32'd0);
      tick();
      chk("add_result", result_out, 32'h80000000);
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_dest", {27'd0, dest_reg_out}, 32'd5);
      chk("add_pc", pc_out, 32'h100);
      chk("add_rwe", {31'd0, reg_write_en_out}, 32'd1);

      drive(4'd7, 32'h80000000, 32'h00000024, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sra_result", result_out, 32'hF8000000);
      drive(4'd9, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sltu_result", result_out, 32'h1);
      drive(4'd8, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("slt_result", result_out, 32'h1);
      drive(4'd1, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sub_result", result_out, 32'hFFFFFFFF);
      drive(4'd5, 32'h1, 32'h1F, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sll_result", result_out, 32'h80000000);
      drive(4'd6, 32'h80000000, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("srl_result", result_out, 32'h08000000);
      drive(4'd4, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("xor_result", result_out, 32'hF0F0F0F0);
      drive(4'd13, 32'h5, 32'h6, 32'hABCDE000, 1'b0, 1'b0, 1'b1);
      tick();
      chk("lui_result", result_out, 32'hABCDE000);
      drive(4'd14, 32'h5, 32'h6, 32'h2000, 1'b0, 1'b0, 1'b1);
      tick();
      chk("auipc_result", result_out, 32'h2100);
      drive(4'd15, 32'h10, 32'h6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
      tick();
      chk("addi_result", result_out, 32'hF);

      // Store: memory_enable overrides the op field
      drive(4'd4, 32'h1000, 32'hDEADBEEF, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0);
      tick();
      chk("st_result", result_out, 32'h00000FFC);
      chk("st_data", store_data_out, 32'hDEADBEEF);
      chk("st_mwe", {31'd0, mem_write_en_out}, 32'd1);
      chk("st_me", {31'd0, memory_enable_out}, 32'd1);
      chk("st_rwe", {31'd0, reg_write_en_out}, 32'd0);

      // Bubble
      in_valid = 1'b0;
      tick();
      chk("bub_valid", {31'd0, out_valid}, 32'd0);
      chk("bub_mwe", {31'd0, mem_write_en_out}, 32'd0);
      chk("bub_me", {31'd0, memory_enable_out}, 32'd0);

      // Flush kills a valid instruction
      drive(4'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_rwe", {31'd0, reg_write_en_out}, 32'd0);
      chk("fl_mwe", {31'd0, mem_write_en_out}, 32'd0);

`ifdef EX_MULDIV_EN
      dest_reg_in = 5'd9; pc_in = 32'h200;
      run_md("mul", 4'd10, 32'h00012345, 32'h00001000, 32'h12345000);
      chk("mul_dest", {27'd0, dest_reg_out}, 32'd9);
      drive(4'd0, 32'h3, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("post_mul_stall", {31'd0, stall_out}, 32'd0);
      tick();
      chk("post_mul_add", result_out, 32'h7);
      chk("post_mul_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("post_mul_once", {31'd0, out_valid}, 32'd0);

      run_md("divu0", 4'd11, 32'd100, 32'd0, 32'hFFFFFFFF);
      run_md("remu", 4'd12, 32'd100, 32'd7, 32'd2);
      run_md("divu", 4'd11, 32'd100, 32'd7, 32'd14);
      run_md("remu0", 4'd12, 32'd100, 32'd0, 32'd100);

      // Flush at iteration 10 of a divide
      drive(4'd11, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      repeat (10) tick();
      chk("md_fl_busy_stall", {31'd0, stall_out}, 32'd1);
      flush_in = 1'b1;
      #1;
      chk("md_fl_stall", {31'd0, stall_out}, 32'd0);
      tick();
      flush_in = 1'b0;
      chk("md_fl_valid", {31'd0, out_valid}, 32'd0);
      drive(4'd0, 32'h20, 32'h22, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("md_fl_idle_stall", {31'd0, stall_out}, 32'd0);
      tick();
      chk("md_fl_next", result_out, 32'h42);
      chk("md_fl_next_valid", {31'd0, out_valid}, 32'd1);

      // Async reset mid-BUSY
      drive(4'd11, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("md_rst_stall", {31'd0, stall_out}, 32'd0);
      chk("md_rst_result", result_out, 32'h0);
      chk("md_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("md_rst_pc", pc_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(4'd0, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("md_rst_next", result_out, 32'hB);
`else
      // Without the multiplier ops 10..12 are single-cycle and produce zero
      drive(4'd0, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("pre_mul_add", result_out, 32'h33);
      drive(4'd10, 32'h00012345, 32'h00001000, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("nomd_mul_stall", {31'd0, stall_out}, 32'd0);
      tick();
      chk("nomd_mul_result", result_out, 32'h0);
      chk("nomd_mul_valid", {31'd0, out_valid}, 32'd1);
      chk("nomd_mul_rwe", {31'd0, reg_write_en_out}, 32'd1);
      drive(4'd11, 32'd100, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("nomd_divu_result", result_out, 32'h0);
      drive(4'd0, 32'h40, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("nomd_add_result", result_out, 32'h42);
      drive(4'd12, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("nomd_remu_stall", {31'd0, stall_out}, 32'd0);
      tick();
      chk("nomd_remu_result", result_out, 32'h0);

      // Async reset clears outputs without a clock edge
      drive(4'd0, 32'h40, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      #1;
      chk("arst_result", result_out, 32'h0);
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_store", store_data_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(4'd0, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("arst_next", result_out, 32'hB);
`endif

      in_valid = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
